// File: rtl/mem_ctrl_if.sv
// Request/response bus between proc and mem_ctrl: proc drives the request side,
// the controller returns read data with a one-cycle ready strobe.
interface mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int BUS_AW = 32
);
    logic                req;
    logic                W;
    logic [BUS_AW-1:0]   realaddr;
    logic [DATA_W-1:0]   dout;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   din;
    logic                ready;
    logic                err;

    modport master (output req, W, realaddr, dout, be, input din, ready, err);
    modport slave  (input req, W, realaddr, dout, be, output din, ready, err);
endinterface

// File: rtl/mem_ctrl.sv
// Word memory behind a req/ready handshake with wait states, byte-enable writes and
// out-of-range detection. Define MEM_STATS_EN to add saturating access counters.
module mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int BUS_AW      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    mem_ctrl_if.slave   bus
`ifdef MEM_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] err_count
`endif
);
    localparam int             NB    = DATA_W / 8;
    localparam int             DEPTH = 2 ** ADDR_W;
    localparam logic [7:0]     WC8   = 8'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                w_q;
    logic [BUS_AW-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       be_q;
    logic [DATA_W-1:0]   din_q;
    logic                err_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept, access, wr_en;
    logic                acc_w, acc_oor;
    logic [BUS_AW-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [NB-1:0]       acc_be;
    logic [ADDR_W-1:0]   acc_idx;

    assign accept = (state_q == IDLE) && bus.req;
    assign access = (WAIT_CYCLES == 0) ? accept : ((state_q == WAIT) && (cnt_q == 8'd1));

    // With no wait states the access happens on the acceptance edge, so it uses the live bus.
    assign acc_w     = (WAIT_CYCLES == 0) ? bus.W        : w_q;
    assign acc_addr  = (WAIT_CYCLES == 0) ? bus.realaddr : addr_q;
    assign acc_wdata = (WAIT_CYCLES == 0) ? bus.dout     : wdata_q;
    assign acc_be    = (WAIT_CYCLES == 0) ? bus.be       : be_q;
    assign acc_idx   = acc_addr[ADDR_W-1:0];
    assign acc_oor   = |acc_addr[BUS_AW-1:ADDR_W];
    assign wr_en     = access && resetn && acc_w && !acc_oor;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.req) begin
                state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                cnt_d   = WC8;
            end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state_q == RESP);
        bus.err   = err_q;
        bus.din   = din_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            din_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (access) begin
                err_q <= acc_oor;
                if (!acc_w) din_q <= acc_oor ? '0 : mem_q[acc_idx];
            end else if (state_q == RESP) begin
                err_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            w_q     <= bus.W;
            addr_q  <= bus.realaddr;
            wdata_q <= bus.dout;
            be_q    <= bus.be;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (acc_be[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

`ifdef MEM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (access) begin
            if (acc_oor)    err_cnt_q <= sat_inc(err_cnt_q);
            else if (acc_w) wr_cnt_q  <= sat_inc(wr_cnt_q);
            else            rd_cnt_q  <= sat_inc(rd_cnt_q);
        end
    end

    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = err_cnt_q;
`endif
endmodule
